// File: rtl/ic_output_writer_pkg.sv
// Shared constants for the JPEG output writer: FSM encoding, FIFO default depth,
// address stride and the byte-reversal helper.
package ic_output_writer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int OW_FIFO_DEPTH_DEFAULT = 16;
  localparam int OW_ADDR_INC           = 4;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ic_ow_fifo.sv
// Synchronous word FIFO for the output writer; a pop frees a slot for a
// same-cycle push even when full, and flush empties it in one cycle.
module ic_ow_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/ic_output_writer.sv
// Buffers compressed JPEG words and streams them to memory at consecutive
// addresses. Optional macro OW_BYTE_SWAP_EN byte-reverses each written word.
module ic_output_writer
  import ic_output_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = OW_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              OW_start,
  input  logic [ADDR_W-1:0] OW_base_address,
  input  logic              OW_inputready,
  input  logic [31:0]       OW_readdata,
  input  logic              OW_EndOfImage,
  input  logic [31:0]       OW_ByteCount,
  input  logic              OW_waitrequest,
  output logic              OW_write,
  output logic [ADDR_W-1:0] OW_address,
  output logic [31:0]       OW_writedata,
  output logic              OW_done,
  output logic [31:0]       OW_total_bytes,
  output logic              OW_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       total_reg;
  logic              overflow_reg;
  logic              active;
  logic              start_ok;
  logic              push;
  logic              pop;
  logic [31:0]       head;
  logic [31:0]       data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign active   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign start_ok = OW_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign push     = OW_inputready && (state_reg == ST_RUN);
  assign OW_write = active && !fifo_empty;
  assign pop      = OW_write && !OW_waitrequest;

  ic_ow_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (start_ok),
    .push    (push),
    .pop     (pop),
    .wdata   (OW_readdata),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef OW_BYTE_SWAP_EN
  assign data_out = byte_swap32(head);
`else
  assign data_out = head;
`endif

  // Data is forced to zero whenever no write is presented, which also covers reset.
  assign OW_writedata   = OW_write ? data_out : '0;
  assign OW_address     = addr_reg;
  assign OW_done        = (state_reg == ST_DONE);
  assign OW_total_bytes = total_reg;
  assign OW_overflow    = overflow_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      total_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (start_ok) begin
      state_reg    <= ST_RUN;
      addr_reg     <= OW_base_address;
      total_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (pop) addr_reg <= addr_reg + ADDR_W'(OW_ADDR_INC);
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
      case (state_reg)
        ST_RUN: begin
          if (OW_EndOfImage) begin
            total_reg <= OW_ByteCount;
            state_reg <= ST_DRAIN;
          end
        end
        // Empty in DRAIN implies no write is being presented this cycle.
        ST_DRAIN: if (fifo_count == '0) state_reg <= ST_DONE;
        default:  state_reg <= state_reg;
      endcase
    end
  end

endmodule

// File: doc/ic_output_writer.md
IC_OUTPUT_WRITER -- requirements
Module: ic_output_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, the number of 32-bit words buffered; it must be a power of two, at least 4.
REQ-002 The block SHALL have parameter ADDR_W, default 32, the width of the memory byte address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port OW_start, input, 1 bit: one-cycle pulse that starts an image.
REQ-006 The block SHALL have port OW_base_address, input, ADDR_W bits: destination byte address, latched on OW_start.
REQ-007 The block SHALL have port OW_inputready, input, 1 bit: compressed-word strobe from the JPEG compression output.
REQ-008 The block SHALL have port OW_readdata, input, 32 bits: compressed word, valid when OW_inputready=1.
REQ-009 The block SHALL have port OW_EndOfImage, input, 1 bit: end-of-image level from the compressor.
REQ-010 The block SHALL have port OW_ByteCount, input, 32 bits: final compressed byte count, valid while OW_EndOfImage=1.
REQ-011 The block SHALL have port OW_waitrequest, input, 1 bit: memory-side stall.
REQ-012 The block SHALL have port OW_write, output, 1 bit: memory write request.
REQ-013 The block SHALL have port OW_address, output, ADDR_W bits: memory byte address.
REQ-014 The block SHALL have port OW_writedata, output, 32 bits: memory write data.
REQ-015 The block SHALL have port OW_done, output, 1 bit: image fully written to memory.
REQ-016 The block SHALL have port OW_total_bytes, output, 32 bits: byte count latched at end of image.
REQ-017 The block SHALL have port OW_overflow, output, 1 bit: sticky flag set when a word is lost because the FIFO was full.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE or DONE, OW_start=1 SHALL latch OW_base_address, clear OW_total_bytes, OW_overflow and OW_done, empty the FIFO, and enter RUN on the next cycle.
REQ-020 OW_inputready SHALL push OW_readdata into the FIFO only in RUN; in all other states the input is ignored.
REQ-021 When the FIFO is non-empty in RUN or DRAIN, OW_write SHALL be 1 and OW_writedata SHALL be the FIFO head.
REQ-022 A write SHALL be accepted when OW_write=1 and OW_waitrequest=0; on acceptance the FIFO pops and OW_address increments by 4, wrapping modulo 2^ADDR_W.
REQ-023 While OW_waitrequest=1, OW_write, OW_address and OW_writedata SHALL hold stable.
REQ-024 Latency from push into an empty FIFO to OW_write=1 SHALL be 1 cycle.
REQ-025 A push and a pop in the same cycle SHALL both succeed, even when the FIFO is full, with occupancy unchanged.
REQ-026 A push when the FIFO is full and no pop occurs SHALL drop the word and set OW_overflow, which stays set until the next OW_start or reset.
REQ-027 OW_EndOfImage=1 in RUN SHALL latch OW_ByteCount into OW_total_bytes and enter DRAIN.
REQ-028 A word strobed in the same cycle as OW_EndOfImage SHALL still be pushed.
REQ-029 DRAIN SHALL move to DONE in the cycle after the FIFO becomes empty with no write outstanding.
REQ-030 In DONE, OW_done SHALL be 1 and SHALL hold until OW_start or reset.
REQ-031 OW_start while in RUN or DRAIN SHALL be ignored.

Reset
REQ-032 When reset_n=0, the block SHALL asynchronously enter IDLE and empty the FIFO.
REQ-033 During reset, OW_write, OW_done and OW_overflow SHALL be 0, and OW_address, OW_writedata and OW_total_bytes SHALL be 0.
REQ-034 A reset during RUN or DRAIN SHALL abandon the image; no write is issued after reset asserts.

Configuration
REQ-035 With macro OW_BYTE_SWAP_EN defined, OW_writedata SHALL be the FIFO head byte-reversed ({[7:0],[15:8],[23:16],[31:24]}), giving JPEG stream byte order in little-endian memory.
REQ-036 With OW_BYTE_SWAP_EN undefined, OW_writedata SHALL equal the FIFO head unchanged.

Structure
REQ-037 Package ic_output_writer_pkg SHALL hold the FSM state encoding, the FIFO_DEPTH default and the address increment constant (4).
REQ-038 The FIFO SHALL be a separate sub-module, ic_ow_fifo: synchronous, with full, empty and occupancy count outputs.

Verification
REQ-039 Reset, then start with base 0x1000, push 3 words, raise EOI with ByteCount 12, waitrequest=0 -> writes to 0x1000, 0x1004, 0x1008 in order, then OW_done=1 and OW_total_bytes=12.
REQ-040 Hold waitrequest=1 for 5 cycles while pushing 4 words -> write, address and data stay stable; after release, all 4 words are written in order; overflow stays 0.
REQ-041 Hold waitrequest=1 and push 17 words with FIFO_DEPTH=16 -> OW_overflow=1; exactly 16 words are written after release.
REQ-042 Push a word in the same cycle as EOI -> that word is written before OW_done rises.
REQ-043 Assert reset_n=0 mid-DRAIN -> OW_write=0 immediately; after restart with base 0x2000, the first write goes to 0x2000.
REQ-044 With OW_BYTE_SWAP_EN defined, push 0x11223344 -> OW_writedata=0x44332211; with it undefined -> 0x11223344.
